gate_test_sequencer: RTL and testbench
======================================

// Module: gate_test_sequencer
// PURPOSE
//  Hardware self-test controller for a small combinational gate (e.g. nor_gate).
//  Drives every input combination onto the gate, waits a settle time, and compares
//  the gate output against a parameterised truth table. Reports a pass/fail
//  summary and a mismatch count. Sits beside the gate under test in a BIST wrapper.
// PARAMETERS
//  NUM_INPUTS   2        gate input width; 2**NUM_INPUTS vectors are applied
//  HOLD_CYCLES  2        settle cycles per vector before sampling (>=1)
//  EXPECTED     4'b0001  truth table, width 2**NUM_INPUTS; bit v = expected output for vector v
// PORTS
//  clk       in   1             single clock; all state on rising edge
//  rst_n     in   1             asynchronous, active-low reset
//  start     in   1             1-cycle request to begin a run; sampled only in IDLE
//  abort     in   1             synchronous abort of a run in progress
//  gate_in   out  NUM_INPUTS    vector driven to the gate under test
//  gate_out  in   1             gate response
//  busy      out  1             high from the cycle after start until DONE exits
//  done      out  1             1-cycle pulse at end of a complete run
//  pass      out  1             1 if last complete run had zero mismatches; held
//  err_cnt   out  NUM_INPUTS+1  mismatches in current/last run (max 2**NUM_INPUTS, no wrap)
// BEHAVIOUR
//  Reset: state=IDLE, gate_in=0, busy=0, done=0, pass=0, err_cnt=0, hold_cnt=0, vec=0.
//  FSM: IDLE -> DRIVE -> CHECK -> (DRIVE | DONE) -> IDLE.
//   IDLE : start=1 & abort=0 -> DRIVE; vec=0, gate_in=0, hold_cnt=0, err_cnt=0, pass=0.
//   DRIVE: hold_cnt increments; at hold_cnt==HOLD_CYCLES-1 -> CHECK.
//   CHECK: 1 cycle; if gate_out != EXPECTED[vec] then err_cnt++.
//          vec==2**NUM_INPUTS-1 -> DONE; else vec++, gate_in=vec+1, hold_cnt=0 -> DRIVE.
//   DONE : done=1 for this cycle only; pass=(final err_cnt==0) set here; -> IDLE.
//  Timing: each vector occupies HOLD_CYCLES+1 cycles; done high exactly
//   1 + 2**NUM_INPUTS*(HOLD_CYCLES+1) cycles after the edge that samples start.
//  err_cnt in CHECK uses the value including the current vector's mismatch for pass.
//  start while busy: ignored. abort in DRIVE/CHECK: -> IDLE next cycle, no done
//   pulse, pass=0, err_cnt holds partial count, gate_in=0. abort+start in IDLE: abort wins.
//  abort in DONE: done still pulses (run complete), then IDLE.
//  rst_n low at any time: immediate return to reset values, no done pulse.
//  gate_in changes only on entry to DRIVE; stable throughout DRIVE and CHECK.
// CONFIGURATION
//  FIRST_FAIL_CAPTURE_EN defined: adds ports
//   fail_valid out 1 / fail_vec out NUM_INPUTS; first mismatching vec of a run is
//   latched in CHECK, fail_valid=1; both cleared (0) on reset and on run start;
//   later mismatches do not overwrite. Undefined: ports and logic absent, other
//   behaviour identical.
// STRUCTURE
//  Shared include gate_seq_defs.vh: state encodings ST_IDLE/ST_DRIVE/ST_CHECK/
//   ST_DONE (2-bit localparams), shared by RTL and bench for state probing.
//  One sub-module: settle_timer (hold_cnt counter, clear/enable in, expire out).
//  FSM, vector counter, comparator and err_cnt stay in this module.
// TESTING
//  Bench instantiates nor_gate as the gate under test, NUM_INPUTS=2.
//  1 NOR, EXPECTED=4'b0001, HOLD=2, start pulse -> gate_in 0,1,2,3 each 3 cycles;
//    done at +13 cycles; pass=1, err_cnt=0.
//  2 Same, EXPECTED=4'b0011 (wrong bit 1) -> done at +13, pass=0, err_cnt=1;
//    with FIRST_FAIL_CAPTURE_EN: fail_valid=1, fail_vec=2'd1.
//  3 EXPECTED=4'b1110 (all wrong) -> err_cnt=4 (no wrap), pass=0; fail_vec=0.
//  4 abort asserted 5 cycles into run -> IDLE next cycle, no done, pass=0,
//    gate_in=0; new start afterwards -> full run passes as in 1.
//  5 start re-pulsed while busy -> ignored, done timing unchanged (+13);
//    start+abort together in IDLE -> stays IDLE, busy=0.
//  6 rst_n low mid-DRIVE -> all outputs reset asynchronously before next edge;
//    release, start -> normal run.

Source files
------------

// File: rtl/gate_test_sequencer_pkg.sv
// Shared state encoding for the gate self-test sequencer; also imported by the bench
// so it can probe the controller state.
package gate_test_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } seqState_t;

    function automatic logic isActive(input seqState_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Settle timer: counts cycles while enabled and flags the last cycle of the hold window.
module settle_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    logic [CW-1:0] r_holdCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdCnt <= '0;
        end else if (i_clear) begin
            r_holdCnt <= '0;
        end else if (i_enable) begin
            r_holdCnt <= r_holdCnt + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_holdCnt == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/nor_gate.sv
// Small combinational gate used as the circuit under self-test.
module nor_gate #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_in,
    output logic         o_out
);

    assign o_out = ~|i_in;

endmodule

// File: rtl/gate_test_sequencer.sv
// BIST sequencer: walks every input vector through a gate and counts truth-table mismatches.
// Optional FIRST_FAIL_CAPTURE_EN adds fail_valid/fail_vec (first mismatching vector of a run).
module gate_test_sequencer
    import gate_test_sequencer_pkg::*;
#(
    parameter int                        NUM_INPUTS  = 2,
    parameter int                        HOLD_CYCLES = 2,
    parameter logic [2**NUM_INPUTS-1:0]  EXPECTED    = 4'b0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [NUM_INPUTS-1:0] gate_in,
    input  logic                  gate_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
`ifdef FIRST_FAIL_CAPTURE_EN
    output logic                  fail_valid,
    output logic [NUM_INPUTS-1:0] fail_vec,
`endif
    output logic [NUM_INPUTS:0]   err_cnt
);

    localparam logic [NUM_INPUTS-1:0] LAST_VEC = '1;

    seqState_t             r_state;
    seqState_t             w_nextState;
    logic [NUM_INPUTS-1:0] r_vec;
    logic [NUM_INPUTS:0]   r_errCnt;
    logic [NUM_INPUTS:0]   w_errNext;
    logic                  r_pass;
    logic                  w_startRun;
    logic                  w_abortRun;
    logic                  w_mismatch;
    logic                  w_expire;

    settle_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_settleTimer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != ST_DRIVE),
        .i_enable (r_state == ST_DRIVE),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort beats both start (in IDLE) and the mismatch count of an in-flight CHECK.
    always_comb begin
        w_nextState = r_state;
        w_startRun  = 1'b0;
        w_abortRun  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_nextState = ST_DRIVE;
                    w_startRun  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    w_nextState = ST_IDLE;
                    w_abortRun  = 1'b1;
                end else if (w_expire) begin
                    w_nextState = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    w_nextState = ST_IDLE;
                    w_abortRun  = 1'b1;
                end else if (r_vec == LAST_VEC) begin
                    w_nextState = ST_DONE;
                end else begin
                    w_nextState = ST_DRIVE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign w_mismatch = (r_state == ST_CHECK) && (gate_out != EXPECTED[r_vec]);
    assign w_errNext  = r_errCnt + {{NUM_INPUTS{1'b0}}, w_mismatch};

    // pass is decided in the last CHECK so it already includes that vector's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec    <= '0;
            r_errCnt <= '0;
            r_pass   <= 1'b0;
        end else if (w_startRun) begin
            r_vec    <= '0;
            r_errCnt <= '0;
            r_pass   <= 1'b0;
        end else if (w_abortRun) begin
            r_vec    <= '0;
            r_pass   <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            r_errCnt <= w_errNext;
            if (r_vec == LAST_VEC) begin
                r_pass <= (w_errNext == '0);
            end else begin
                r_vec <= r_vec + 1'b1;
            end
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    logic                  r_failValid;
    logic [NUM_INPUTS-1:0] r_failVec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_failValid <= 1'b0;
            r_failVec   <= '0;
        end else if (w_startRun) begin
            r_failValid <= 1'b0;
            r_failVec   <= '0;
        end else if (w_mismatch && !w_abortRun && !r_failValid) begin
            r_failValid <= 1'b1;
            r_failVec   <= r_vec;
        end
    end

    assign fail_valid = r_failValid;
    assign fail_vec   = r_failVec;
`endif

    assign gate_in = r_vec;
    assign busy    = isActive(r_state);
    assign done    = (r_state == ST_DONE);
    assign pass    = r_pass;
    assign err_cnt = r_errCnt;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized self-checking bench for gate_test_sequencer driving a NOR gate with injectable faults.
// Build with FIRST_FAIL_CAPTURE_EN defined to also check the first-fail capture ports.
module tb_gate_test_sequencer;
    import gate_test_sequencer_pkg::*;

    localparam int NI         = 2;
    localparam int NV         = 2**NI;
    localparam int HOLD       = 2;
    localparam int PER        = HOLD + 1;
    localparam int DONE_CYCLE = 1 + NV*PER;
    localparam logic [NV-1:0] TB_EXPECTED = 4'b0001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NI-1:0] gateIn;
    logic          norOut;
    logic          gateOut;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NI:0]   errCnt;
    logic [NV-1:0] faultMask = '0;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic          failValid;
    logic [NI-1:0] failVec;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    nor_gate #(.N(NI)) uGate (
        .i_in  (gateIn),
        .o_out (norOut)
    );

    assign gateOut = norOut ^ faultMask[gateIn];

    gate_test_sequencer #(
        .NUM_INPUTS  (NI),
        .HOLD_CYCLES (HOLD),
        .EXPECTED    (TB_EXPECTED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .gate_in    (gateIn),
        .gate_out   (gateOut),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
`ifdef FIRST_FAIL_CAPTURE_EN
        .fail_valid (failValid),
        .fail_vec   (failVec),
`endif
        .err_cnt    (errCnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: a NOR gate answers 1 only for vector 0; the mask flips selected answers.
    function automatic bit refMismatch(input logic [NV-1:0] m, input int v);
        logic [NV-1:0] tbl;
        logic          resp;
        tbl  = TB_EXPECTED;
        resp = ((v == 0) ? 1'b1 : 1'b0) ^ m[v];
        return (resp != tbl[v]);
    endfunction

    function automatic int refErrors(input logic [NV-1:0] m, input int nChecked);
        int n = 0;
        for (int v = 0; v < nChecked; v++) begin
            if (refMismatch(m, v)) n++;
        end
        return n;
    endfunction

    function automatic int refFirstFail(input logic [NV-1:0] m, input int nChecked);
        for (int v = 0; v < nChecked; v++) begin
            if (refMismatch(m, v)) return v;
        end
        return -1;
    endfunction

    // One run: optional start re-pulse while busy and optional abort at a given cycle.
    task automatic applyStimulus(input logic [NV-1:0] mask, input int restartAt, input int abortAt);
        int lastCycle;
        int nChecked;
        int expErr;
        int expFirst;
        faultMask = mask;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lastCycle = (abortAt > 0) ? abortAt : DONE_CYCLE;
        for (int c = 1; c <= lastCycle; c++) begin
            checkOutput("busy_run", busy, 1);
            checkOutput("done_timing", done, (c == DONE_CYCLE) ? 1 : 0);
            checkOutput("gate_in_seq", gateIn, (c < DONE_CYCLE) ? (c - 1) / PER : NV - 1);
            if (c == DONE_CYCLE) begin
                checkOutput("pass_at_done", pass, (refErrors(mask, NV) == 0) ? 1 : 0);
                checkOutput("err_at_done", errCnt, refErrors(mask, NV));
            end
            start = (c == restartAt);
            abort = (c == abortAt);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        nChecked = 0;
        for (int v = 0; v < NV; v++) begin
            if (abortAt == 0 || (v + 1) * PER < abortAt) nChecked++;
        end
        expErr   = refErrors(mask, nChecked);
        expFirst = refFirstFail(mask, nChecked);
        checkOutput("busy_after", busy, 0);
        checkOutput("done_after", done, 0);
        checkOutput("gate_in_after", gateIn, (abortAt > 0) ? 0 : NV - 1);
        checkOutput("pass_after", pass, (abortAt == 0 && expErr == 0) ? 1 : 0);
        checkOutput("err_after", errCnt, expErr);
`ifdef FIRST_FAIL_CAPTURE_EN
        checkOutput("fail_valid", failValid, (expFirst >= 0) ? 1 : 0);
        checkOutput("fail_vec", failVec, (expFirst >= 0) ? expFirst : 0);
`endif
        @(negedge clk);
        checkOutput("done_quiet", done, 0);
        checkOutput("pass_held", pass, (abortAt == 0 && expErr == 0) ? 1 : 0);
    endtask

    task automatic resetMidRun(input logic [NV-1:0] mask);
        faultMask = mask;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_state", dut.r_state, ST_IDLE);
        checkOutput("rst_gate_in", gateIn, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_err", errCnt, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
        checkOutput("rst_fail_valid", failValid, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NV-1:0] m;
        int ra;
        int aa;
        #12;
        checkOutput("reset_gate_in", gateIn, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_pass", pass, 0);
        checkOutput("reset_err", errCnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(4'b0000, 0, 0);
        applyStimulus(4'b0010, 0, 0);
        applyStimulus(4'b1111, 0, 0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", busy, 0);
        checkOutput("start_abort_err", errCnt, 4);
        @(negedge clk);
        checkOutput("start_abort_idle", busy, 0);

        applyStimulus(NV'($urandom), 0, 5);
        applyStimulus(4'b0000, 0, 0);
        applyStimulus(4'b0000, 7, 0);

        for (int i = 0; i < 12; i++) begin
            m  = NV'($urandom);
            ra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DONE_CYCLE) : 0;
            aa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DONE_CYCLE - 1) : 0;
            applyStimulus(m, ra, aa);
        end

        resetMidRun(NV'($urandom));
        applyStimulus(4'b0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
